mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequencer that sits directly upstream of the team's 4-to-1 combinational mux. It drives the mux select lines `s1`/`s0` through channels 0→3 and waits a programmable settle time on each channel. It then captures the mux output `z` per channel and presents the 4-bit snapshot downstream with a valid/ready handshake. It turns the mux into a scanned 4-channel sampler, with single-shot and continuous modes.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each select value is held before sampling. Legal range 1..15.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a scan. Accepted only in IDLE; ignored in all other states.
- `cont`  input  1  continuous mode, sampled at each output handshake.
- `abort`  input  1  synchronous abort from any state.
- `z`  input  1  mux output, sampled in SAMPLE state.
- `s1`  output  1  mux select MSB, equal to `sel[1]`.
- `s0`  output  1  mux select LSB, equal to `sel[0]`.
- `busy`  output  1  high in SETTLE and SAMPLE.
- `out_valid`  output  1  snapshot available; high exactly in DONE.
- `out_ready`  input  1  downstream accepts the snapshot.
- `out_data`  output  4  captured values; bit *n* is channel *n*.
- `scan_count`  output  8  completed-scan counter; wraps 255→0.

## Operation
- Internal state:
  - 2-bit `sel`;
  - 4-bit settle counter `cnt`;
  - 4-bit data register;
  - FSM with states IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `sel`=0, so `s1`=`s0`=0.
  - `start`=1 moves to SETTLE with `sel`=0 and `cnt`=SETTLE_CYCLES-1.
- SETTLE:
  - `cnt` decrements each cycle.
  - When `cnt`=0, moves to SAMPLE.
  - `sel` is held constant throughout.
- SAMPLE (one cycle):
  - `data[sel]` ← `z`.
  - If `sel`=3, moves to DONE.
  - Otherwise `sel` ← `sel`+1, `cnt` reloads to SETTLE_CYCLES-1, and the FSM returns to SETTLE.
- DONE:
  - `out_valid`=1.
  - `out_data` and `sel`(=3) are held stable until the handshake.
  - On `out_valid`&&`out_ready`, `scan_count` increments (modulo 256).
  - If `cont`=1 at that edge: go to SETTLE with `sel`=0 and `cnt` reloaded.
  - Otherwise: go to IDLE with `sel`=0.
- `abort`=1 at any edge:
  - Goes to IDLE with `sel`=0 and `out_valid` low next cycle.
  - Data register is not modified and `scan_count` does not increment.
  - `abort` has priority over `start`, the handshake and state advance.
- `out_data` always reflects the data register. It is only meaningful while `out_valid`=1. Partial results from an aborted scan remain visible but are never validated.
- `start` asserted in DONE or mid-scan has no effect. It is not queued.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state IDLE;
  - `sel`=0, hence `s1`=`s0`=0;
  - `cnt`=0;
  - `busy`=0, `out_valid`=0;
  - `out_data`=4'b0000, `scan_count`=8'd0.
- Reset asserted mid-scan or in DONE takes effect immediately without waiting for a clock edge. Operation resumes on the first rising edge after `rst_n` deasserts.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Per-channel cost is SETTLE_CYCLES+1 cycles.
  - `z` is captured at the end of the (SETTLE_CYCLES+1)-th cycle that `sel` holds a value.
  - The mux therefore has at least SETTLE_CYCLES full cycles of settle time.
- Latency: a `start` sampled at edge E gives `out_valid`=1 in the cycle after edge E+4·(SETTLE_CYCLES+1). With default SETTLE_CYCLES=2 this is 12 edges after the start edge.
- Continuous mode: consecutive snapshots are 4·(SETTLE_CYCLES+1)+1 cycles apart when `out_ready` is tied high. DONE lasts at least 1 cycle.
- Backpressure: DONE holds indefinitely while `out_ready`=0. No sample is lost or overwritten.
- `scan_count` wrap: handshake at 255 gives 0. No flag is raised.
- Simultaneous `abort`+`out_ready` in DONE: abort wins, with no count increment and no restart.

## Test plan
- Reset then single scan, SETTLE_CYCLES=2:
  - Stimulus: `z` driven as channel pattern c0..c3=1,0,1,1 via a mux model; `start` pulsed once; `out_ready`=1.
  - Required: `s1s0` steps 00,01,10,11, each held 3 cycles; `out_valid` high 12 edges after start for exactly 1 cycle; `out_data`=4'b1101; `scan_count`=1; FSM returns to IDLE with `s1s0`=00.
- Backpressure:
  - Stimulus: `out_ready`=0 for 20 cycles after `out_valid` rises, then 1.
  - Required: `out_valid`, `out_data` and `s1s0`=11 all stable for the 20 cycles; single count increment on release.
- Continuous mode:
  - Stimulus: `cont`=1, `out_ready`=1, `z` pattern changed between scans (4'b0101 then 4'b1010).
  - Required: `out_valid` pulses every 13 cycles; `out_data` shows 4'b0101 then 4'b1010; `start` pulses during the scans are ignored.
- Abort mid-scan:
  - Stimulus: `abort` asserted while `sel`=2.
  - Required: next cycle IDLE, `busy`=0, `s1s0`=00, `out_valid` never asserts, `scan_count` unchanged.
  - Follow-up: a new `start` completes normally.
- Async reset in DONE:
  - Stimulus: `rst_n` dropped between clock edges while `out_valid`=1.
  - Required: `out_valid`, `out_data`, `scan_count` and `s1s0` go to 0 immediately.
- Counter wrap:
  - Stimulus: 256 back-to-back scans.
  - Required: `scan_count` reads 255 after scan 255 and 0 after scan 256.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// Bundles the scan controller's command, mux-side and snapshot handshake signals.
// The master drives commands, the mux output and out_ready; the slave is the controller.
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       abort;
  logic       z;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [7:0] scan_count;

  modport master (
    output start, cont, abort, z, out_ready,
    input  s1, s0, busy, out_valid, out_data, scan_count
  );

  modport slave (
    input  start, cont, abort, z, out_ready,
    output s1, s0, busy, out_valid, out_data, scan_count
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux through channels 0..3 and holds each for SETTLE_CYCLES+1 cycles; snapshot valid 4*(SETTLE_CYCLES+1) edges after start.
// The snapshot is held in DONE until out_ready; nothing advances or is overwritten under backpressure.
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_ctrl_if.slave bus
);
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t     state;
  logic [1:0] sel;
  logic [3:0] cnt;
  logic [3:0] data;
  logic [7:0] scan_count;
  logic       busy;
  logic       out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 2'd0;
      cnt        <= 4'd0;
      data       <= 4'd0;
      scan_count <= 8'd0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
    end else if (bus.abort) begin
      // Abort keeps data and count untouched; partial results stay visible but unvalidated.
      state     <= IDLE;
      sel       <= 2'd0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel <= 2'd0;
          if (bus.start) begin
            state <= SETTLE;
            cnt   <= RELOAD;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) state <= SAMPLE;
          else             cnt   <= cnt - 4'd1;
        end
        SAMPLE: begin
          data[sel] <= bus.z;
          if (sel == 2'd3) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            state <= SETTLE;
            sel   <= sel + 2'd1;
            cnt   <= RELOAD;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            scan_count <= scan_count + 8'd1;
            out_valid  <= 1'b0;
            sel        <= 2'd0;
            if (bus.cont) begin
              state <= SETTLE;
              cnt   <= RELOAD;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          sel       <= 2'd0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s1         = sel[1];
  assign bus.s0         = sel[0];
  assign bus.busy       = busy;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = data;
  assign bus.scan_count = scan_count;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with SETTLE_CYCLES=2 and a behavioural 4:1 mux driving z.
module tb_mux_scan_ctrl;
  logic       clk;
  logic       rst_n;
  logic [3:0] pat;
  int         checks;
  int         errors;
  logic [7:0] exp_cnt;

  mux_scan_ctrl_if bus_if ();

  mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus_if.z = pat[{bus_if.s1, bus_if.s0}];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.start = 1'b0;
    bus_if.cont = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.out_ready = 1'b1;
    pat = 4'b0000;
    exp_cnt = 8'd0;
    #12;
    checks++;
    if ({bus_if.s1, bus_if.s0, bus_if.busy, bus_if.out_valid, bus_if.out_data, bus_if.scan_count} !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got s1s0=%b busy=%b valid=%b data=%b cnt=%0d, want all zero",
               {bus_if.s1, bus_if.s0}, bus_if.busy, bus_if.out_valid, bus_if.out_data, bus_if.scan_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_scan();
    pat = 4'b1101;
    bus_if.cont = 1'b0;
    bus_if.out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      checks++;
      if ({bus_if.s1, bus_if.s0, bus_if.out_valid, bus_if.busy} !== {2'(k / 3), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL single_step%0d: got s1s0=%b valid=%b busy=%b, want s1s0=%b valid=0 busy=1",
                 k, {bus_if.s1, bus_if.s0}, bus_if.out_valid, bus_if.busy, 2'(k / 3));
      end
      tick();
    end
    checks++;
    if ({bus_if.out_valid, bus_if.busy, bus_if.s1, bus_if.s0, bus_if.out_data} !== {1'b1, 1'b0, 2'b11, 4'b1101}) begin
      errors++;
      $display("FAIL single_done: got valid=%b busy=%b s1s0=%b data=%b, want valid=1 busy=0 s1s0=11 data=1101",
               bus_if.out_valid, bus_if.busy, {bus_if.s1, bus_if.s0}, bus_if.out_data);
    end
    tick();
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if ({bus_if.out_valid, bus_if.busy, bus_if.s1, bus_if.s0, bus_if.scan_count} !== {4'b0000, exp_cnt}) begin
      errors++;
      $display("FAIL single_idle: got valid=%b busy=%b s1s0=%b cnt=%0d, want 0 0 00 cnt=%0d",
               bus_if.out_valid, bus_if.busy, {bus_if.s1, bus_if.s0}, bus_if.scan_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    pat = 4'b0110;
    bus_if.out_ready = 1'b0;
    pulse_start();
    repeat (12) tick();
    for (int k = 0; k <= 20; k++) begin
      checks++;
      if ({bus_if.out_valid, bus_if.out_data, bus_if.s1, bus_if.s0, bus_if.scan_count} !== {1'b1, 4'b0110, 2'b11, exp_cnt}) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got valid=%b data=%b s1s0=%b cnt=%0d, want 1 0110 11 cnt=%0d",
                 k, bus_if.out_valid, bus_if.out_data, {bus_if.s1, bus_if.s0}, bus_if.scan_count, exp_cnt);
      end
      if (k < 20) tick();
    end
    bus_if.out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if ({bus_if.out_valid, bus_if.scan_count} !== {1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL backpressure_release: got valid=%b cnt=%0d, want valid=0 cnt=%0d",
               bus_if.out_valid, bus_if.scan_count, exp_cnt);
    end
  endtask

  task automatic test_continuous();
    pat = 4'b0101;
    bus_if.cont = 1'b1;
    bus_if.out_ready = 1'b1;
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      bus_if.start = (k == 4);
      tick();
    end
    bus_if.start = 1'b0;
    checks++;
    if ({bus_if.out_valid, bus_if.out_data} !== {1'b1, 4'b0101}) begin
      errors++;
      $display("FAIL cont_first: got valid=%b data=%b, want valid=1 data=0101", bus_if.out_valid, bus_if.out_data);
    end
    pat = 4'b1010;
    for (int k = 1; k <= 13; k++) begin
      bus_if.start = (k == 6);
      tick();
      if (k < 13) begin
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL cont_gap%0d: got valid=%b, want 0", k, bus_if.out_valid);
        end
      end
    end
    bus_if.start = 1'b0;
    checks++;
    if ({bus_if.out_valid, bus_if.out_data} !== {1'b1, 4'b1010}) begin
      errors++;
      $display("FAIL cont_second: got valid=%b data=%b, want valid=1 data=1010", bus_if.out_valid, bus_if.out_data);
    end
    bus_if.cont = 1'b0;
    tick();
    exp_cnt = exp_cnt + 8'd2;
    repeat (3) tick();
    checks++;
    if ({bus_if.busy, bus_if.out_valid, bus_if.scan_count} !== {2'b00, exp_cnt}) begin
      errors++;
      $display("FAIL cont_stop: got busy=%b valid=%b cnt=%0d, want 0 0 cnt=%0d",
               bus_if.busy, bus_if.out_valid, bus_if.scan_count, exp_cnt);
    end
  endtask

  task automatic test_abort();
    logic seen_valid;
    pat = 4'b1111;
    bus_if.out_ready = 1'b1;
    pulse_start();
    repeat (7) tick();
    checks++;
    if ({bus_if.s1, bus_if.s0} !== 2'b10) begin
      errors++;
      $display("FAIL abort_presel: got s1s0=%b, want 10", {bus_if.s1, bus_if.s0});
    end
    bus_if.abort = 1'b1;
    bus_if.start = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    bus_if.start = 1'b0;
    checks++;
    if ({bus_if.busy, bus_if.s1, bus_if.s0, bus_if.out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b s1s0=%b valid=%b, want 0 00 0",
               bus_if.busy, {bus_if.s1, bus_if.s0}, bus_if.out_valid);
    end
    seen_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      seen_valid = seen_valid | bus_if.out_valid;
    end
    checks++;
    if ({seen_valid, bus_if.scan_count, bus_if.out_data} !== {1'b0, exp_cnt, 4'b1011}) begin
      errors++;
      $display("FAIL abort_quiet: got seen_valid=%b cnt=%0d data=%b, want 0 cnt=%0d data=1011",
               seen_valid, bus_if.scan_count, bus_if.out_data, exp_cnt);
    end
    pulse_start();
    repeat (12) tick();
    checks++;
    if ({bus_if.out_valid, bus_if.out_data} !== {1'b1, 4'b1111}) begin
      errors++;
      $display("FAIL abort_followup: got valid=%b data=%b, want valid=1 data=1111", bus_if.out_valid, bus_if.out_data);
    end
    tick();
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if (bus_if.scan_count !== exp_cnt) begin
      errors++;
      $display("FAIL abort_followup_cnt: got %0d, want %0d", bus_if.scan_count, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    pat = 4'b1001;
    bus_if.out_ready = 1'b0;
    pulse_start();
    repeat (12) tick();
    checks++;
    if ({bus_if.out_valid, bus_if.out_data} !== {1'b1, 4'b1001}) begin
      errors++;
      $display("FAIL areset_pre: got valid=%b data=%b, want valid=1 data=1001", bus_if.out_valid, bus_if.out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.out_valid, bus_if.out_data, bus_if.scan_count, bus_if.s1, bus_if.s0, bus_if.busy} !== 16'd0) begin
      errors++;
      $display("FAIL areset_now: got valid=%b data=%b cnt=%0d s1s0=%b busy=%b, want all zero",
               bus_if.out_valid, bus_if.out_data, bus_if.scan_count, {bus_if.s1, bus_if.s0}, bus_if.busy);
    end
    tick();
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    exp_cnt = 8'd0;
    checks++;
    if ({bus_if.out_valid, bus_if.busy, bus_if.scan_count} !== {2'b00, exp_cnt}) begin
      errors++;
      $display("FAIL areset_after: got valid=%b busy=%b cnt=%0d, want 0 0 0",
               bus_if.out_valid, bus_if.busy, bus_if.scan_count);
    end
  endtask

  task automatic test_wrap();
    int n;
    pat = 4'b0011;
    bus_if.cont = 1'b1;
    bus_if.out_ready = 1'b1;
    pulse_start();
    for (int i = 1; i <= 256; i++) begin
      n = 0;
      while (bus_if.out_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (bus_if.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_timeout scan %0d: valid=%b after %0d cycles, want 1", i, bus_if.out_valid, n);
      end
      if (i == 256) bus_if.cont = 1'b0;
      tick();
      if (i == 255) begin
        checks++;
        if (bus_if.scan_count !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got %0d, want 255", bus_if.scan_count);
        end
      end
      if (i == 256) begin
        checks++;
        if ({bus_if.scan_count, bus_if.busy} !== {8'd0, 1'b0}) begin
          errors++;
          $display("FAIL wrap_0: got cnt=%0d busy=%b, want cnt=0 busy=0", bus_if.scan_count, bus_if.busy);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_scan();
    test_backpressure();
    test_continuous();
    test_abort();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
